// File: rtl/uart_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_prog_loader_pkg
// Brief  : RX FSM encoding and upg_* address layout shared with the memories.
// Rev    : 1.0 - initial release
// ============================================================================
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int c_adr_w = 15;
  localparam int c_idx_w = 14;

  // MSB selects dmemory32 (1) over program_rom (0); matches both memories' decode.
  typedef struct packed {
    logic               mem_sel;
    logic [c_idx_w-1:0] idx;
  } upg_adr_t;

  function automatic upg_adr_t make_adr(input logic mem_sel, input logic [c_idx_w-1:0] idx);
    upg_adr_t a;
    a.mem_sel = mem_sel;
    a.idx     = idx;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_prog_loader_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_byte
// Brief  : 8N1 UART receiver with 2-FF synchroniser and mid-bit sampling.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 128_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       rx_idle_o
);

  localparam int c_div   = CLK_HZ / BAUD;
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(c_div / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(c_div - 1);

  generate
    if (c_div < 4) begin : g_div_check
      $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  rx_state_t          r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_rx_prev;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_vld;
  logic               r_frame_err;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= RX_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx_i;
      r_sync2     <= r_sync1;
      r_rx_prev   <= r_sync2;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        // Edge detect also gives the post-framing-error wait for a high line.
        RX_IDLE: begin
          if (r_rx_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == c_half_cnt) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == c_full_cnt) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == c_full_cnt) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              r_byte_vld <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_o      = r_shift;
  assign byte_vld_o  = r_byte_vld;
  assign frame_err_o = r_frame_err;
  assign rx_idle_o   = (r_state == RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_prog_loader
// Brief  : Packs UART bytes into 32-bit words and writes IMEM then DMEM.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 128_000,
  parameter int IMEM_WORDS  = 16384,
  parameter int DMEM_WORDS  = 16384,
  parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
  input  logic                upg_clk_i,
  input  logic                upg_rst_n_i,
  input  logic                upg_rx_i,
  output logic                upg_clk_o,
  output logic                upg_wen_o,
  output logic [c_adr_w-1:0]  upg_adr_o,
  output logic [31:0]         upg_dat_o,
  output logic                upg_done_o,
  output logic                upg_err_o
);

  localparam int c_total = IMEM_WORDS + DMEM_WORDS;
  localparam int c_wc_w  = $clog2(c_total + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_wc_w-1:0] c_imem_wc  = c_wc_w'(IMEM_WORDS);
  localparam logic [c_wc_w-1:0] c_total_wc = c_wc_w'(c_total);
  localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(TIMEOUT_CYC - 1);

  logic [7:0] w_byte;
  logic       w_byte_vld;
  logic       w_frame_err;
  logic       w_rx_idle;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk_i       (upg_clk_i),
    .rst_n_i     (upg_rst_n_i),
    .rx_i        (upg_rx_i),
    .byte_o      (w_byte),
    .byte_vld_o  (w_byte_vld),
    .frame_err_o (w_frame_err),
    .rx_idle_o   (w_rx_idle)
  );

  logic [c_wc_w-1:0] r_wc;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_part;
  logic              r_wen;
  upg_adr_t          r_adr;
  logic [31:0]       r_dat;
  logic              r_done;
  logic              r_err;
  logic              r_any_byte;
  logic [c_to_w-1:0] r_to_cnt;
  upg_adr_t          w_adr;
  logic              w_all_written;

  assign w_all_written = (r_wc == c_total_wc);

  always_comb begin
    w_adr = '0;
    if (r_wc < c_imem_wc) begin
      w_adr = make_adr(1'b0, c_idx_w'(r_wc));
    end else begin
      w_adr = make_adr(1'b1, c_idx_w'(r_wc - c_imem_wc));
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      r_wc       <= '0;
      r_bcnt     <= '0;
      r_part     <= '0;
      r_wen      <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_any_byte <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_wen <= 1'b0;
      if (r_wen && w_all_written) begin
        r_done <= 1'b1;
      end
      if (w_frame_err) begin
        r_err <= 1'b1;
      end
      // A byte landing on the timeout's last cycle takes priority and rearms it.
      if (w_byte_vld) begin
        r_any_byte <= 1'b1;
        r_to_cnt   <= '0;
        if (!r_done && !w_all_written) begin
          if (r_bcnt == 2'd3) begin
            r_wen  <= 1'b1;
            r_dat  <= {w_byte, r_part};
            r_adr  <= w_adr;
            r_wc   <= r_wc + 1'b1;
            r_bcnt <= '0;
          end else begin
            r_part <= {w_byte, r_part[23:8]};
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
      end else if (r_any_byte && !r_done && w_rx_idle) begin
        if (r_to_cnt == c_to_last) begin
          r_done <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign upg_clk_o  = upg_clk_i;
  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;
  assign upg_err_o  = r_err;

endmodule
`default_nettype wire
